// File: rtl/psum_acc.sv
// psum_acc: accumulates partial-sum rows from an upstream output FIFO over one or
// more kernel passes into a row buffer, then streams the ReLU'd rows downstream.
//
// Ports:
//   clk            - single clock, all state updates on the rising edge
//   reset          - synchronous, active-high reset
//   start          - one-cycle job request, honoured only while idle
//   n_pass[3:0]    - kernel passes per job, sampled on an accepted start (0 means 1)
//   ofifo_out      - FIFO head word, lane c at [psum_bw*(c+1)-1 : psum_bw*c]
//   ofifo_o_valid  - FIFO head word is valid
//   ofifo_rd       - pop the FIFO head at this edge
//   out_data       - ReLU'd accumulated row (0 when out_valid is low)
//   out_valid      - out_data is valid
//   out_ready      - downstream accepts out_data
//   busy           - block is not idle
//   done           - one-cycle pulse after the last output row is accepted
module psum_acc #(
    parameter int psum_bw  = 16,
    parameter int col      = 8,
    parameter int len_onij = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [3:0]             n_pass,
    input  logic [col*psum_bw-1:0] ofifo_out,
    input  logic                   ofifo_o_valid,
    output logic                   ofifo_rd,
    output logic [col*psum_bw-1:0] out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   busy,
    output logic                   done
);

    localparam int PtrW = (len_onij > 1) ? $clog2(len_onij) : 1;
    localparam int RowW = col * psum_bw;
    localparam logic [PtrW-1:0] LastPtr = PtrW'(len_onij - 1);

    typedef enum logic [1:0] {StIdle, StAcc, StOut} state_e;

    state_e            state_q, state_d;
    logic [PtrW-1:0]   wptr_q, wptr_d;
    logic [PtrW-1:0]   optr_q, optr_d;
    logic [3:0]        pass_q, pass_d;
    logic [3:0]        npass_q, npass_d;
    logic              done_q, done_d;

    // Row buffer holds no reset: pass 0 overwrites every row before it is read.
    logic [RowW-1:0]   mem_q [len_onij];
    logic [RowW-1:0]   acc_row;
    logic [RowW-1:0]   rd_row;

    // Outputs are gated by reset so the reset cycle itself is quiet.
    assign ofifo_rd  = (state_q == StAcc) && ofifo_o_valid && !reset;
    assign out_valid = (state_q == StOut) && !reset;
    assign busy      = (state_q != StIdle) && !reset;
    assign done      = done_q && !reset;

    // Per-lane accumulate; plain psum_bw-bit addition wraps without saturation.
    always_comb begin
        acc_row = '0;
        for (int c = 0; c < col; c++) begin
            if (pass_q == 4'd0) begin
                acc_row[c*psum_bw +: psum_bw] = ofifo_out[c*psum_bw +: psum_bw];
            end else begin
                acc_row[c*psum_bw +: psum_bw] = mem_q[wptr_q][c*psum_bw +: psum_bw]
                                              + ofifo_out[c*psum_bw +: psum_bw];
            end
        end
    end

    // ReLU on read: a lane with its sign bit set is clamped to zero.
    always_comb begin
        rd_row   = mem_q[optr_q];
        out_data = '0;
        for (int c = 0; c < col; c++) begin
            if (out_valid && !rd_row[c*psum_bw + psum_bw - 1]) begin
                out_data[c*psum_bw +: psum_bw] = rd_row[c*psum_bw +: psum_bw];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        wptr_d  = wptr_q;
        optr_d  = optr_q;
        pass_d  = pass_q;
        npass_d = npass_q;
        done_d  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    npass_d = (n_pass == 4'd0) ? 4'd1 : n_pass;
                    wptr_d  = '0;
                    optr_d  = '0;
                    pass_d  = 4'd0;
                    state_d = StAcc;
                end
            end
            StAcc: begin
                if (ofifo_rd) begin
                    if (wptr_q == LastPtr) begin
                        wptr_d = '0;
                        pass_d = pass_q + 4'd1;
                        if (pass_q == npass_q - 4'd1) begin
                            state_d = StOut;
                        end
                    end else begin
                        wptr_d = wptr_q + 1'b1;
                    end
                end
            end
            StOut: begin
                if (out_ready) begin
                    if (optr_q == LastPtr) begin
                        optr_d  = '0;
                        state_d = StIdle;
                        done_d  = 1'b1;
                    end else begin
                        optr_d = optr_q + 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            wptr_q  <= '0;
            optr_q  <= '0;
            pass_q  <= 4'd0;
            npass_q <= 4'd1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            wptr_q  <= wptr_d;
            optr_q  <= optr_d;
            pass_q  <= pass_d;
            npass_q <= npass_d;
            done_q  <= done_d;
        end
    end

    always_ff @(posedge clk) begin
        if (ofifo_rd) begin
            mem_q[wptr_q] <= acc_row;
        end
    end

endmodule
